mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single-port unified memory between the fetch stage (instruction reads) and the memory stage (LDD reads and store writes) of the pipelined core. It sits between the pipeline and the memory model, and sequences one access at a time over a ready-based memory handshake. It generates the stall signals that freeze the fetch and memory stages while their request is pending. Data accesses have priority, with a bounded anti-starvation rule for fetch.

## Interface
- ADDR_W, 20, address width
- DATA_W, 16, data width
- MAX_CONSEC, 2, maximum back-to-back data grants while a fetch is pending (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done or if_flush
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_flush  in  1  one-cycle pulse that cancels the current fetch (branch/jump)
- halt  in  1  level signal from HLT decode; blocks new fetch grants
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = write, 0 = read; stable with d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  registered fetch data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  registered load data
- if_stall  out  1  if_req & ~if_done
- d_stall  out  1  d_req & ~d_done
- mem_en  out  1  memory access active
- mem_we  out  1  write strobe, valid with mem_en
- mem_addr  out  ADDR_W  latched access address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current access this cycle

## Operation
- States: IDLE, BUSY_IF, BUSY_D, BUSY_IF_CANCEL.
- Arbitration happens only in IDLE:
  - A requester whose done is high this cycle is ineligible.
  - A fetch is eligible only if if_req=1, halt=0 and if_flush=0.
  - If both requesters are eligible: grant fetch when consec=MAX_CONSEC, otherwise grant data.
  - If only one is eligible, grant it. If none, stay in IDLE.
- On grant: latch address, we and wdata into the mem_* registers, then go to BUSY_IF or BUSY_D.
- In any BUSY state: mem_en=1 and mem_* are held stable.
  - mem_ready=1 in BUSY_IF: capture mem_rdata into if_rdata, pulse if_done next cycle, go to IDLE.
  - mem_ready=1 in BUSY_D: pulse d_done next cycle and go to IDLE. On reads, capture d_rdata; on writes, d_rdata is unchanged.
- if_flush during BUSY_IF: go to BUSY_IF_CANCEL. The memory access still completes, then return to IDLE with no if_done and if_rdata unchanged.
- if_flush in the same cycle as mem_ready in BUSY_IF: the fetch is cancelled (no if_done).
- Counter consec (width clog2(MAX_CONSEC+1)):
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, or whenever if_req=0.
  - Saturates at MAX_CONSEC.
- halt does not abort an in-flight fetch. Data accesses continue while halt is high.
- mem_ready outside BUSY states is ignored.
- Reset (asynchronous, any state): state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, consec=0. Any in-flight access is abandoned.

## Timing
- Requests are sampled in IDLE at cycle N. mem_en rises at N+1.
- If mem_ready is high at cycle M ≥ N+1, done is high at M+1 (that cycle is IDLE). Minimum request-to-done latency is 2 cycles.
- The arbiter may grant the other requester in the same cycle it pulses done. Peak throughput is one access per 2 cycles.
- if_done/d_done are exactly one cycle wide. The requester drops or changes its request in the done cycle.
- if_stall and d_stall are combinational from req and done, with no added latency.
- mem_we is never high while mem_en is low.

## Test plan
- Single fetch: if_req=1, if_addr=0x00010, mem_ready=1 the cycle after grant, mem_rdata=0x1234 -> mem_en high for 1 cycle, if_done at cycle 2, if_rdata=0x1234, if_stall high cycles 0-1.
- Contention: if_req and d_req (read 0x00200) both raised at cycle 0 -> data served first (d_done cycle 2), fetch granted at cycle 2, if_done at cycle 4.
- Starvation bound with MAX_CONSEC=2: d_req continuously re-asserted with if_req pending -> exactly 2 data grants, then the fetch, then data resumes.
- Flush mid-fetch: if_flush pulsed while BUSY_IF, mem_ready 3 cycles later -> no if_done, if_rdata unchanged, next fetch (new address) granted afterwards.
- Halt and store: halt=1 with if_req=1 and a d_req write of 0xBEEF to 0x00300 -> only the write is issued (mem_we=1, mem_wdata=0xBEEF), d_done pulses, d_rdata unchanged, fetch never granted until halt=0.
- Reset mid-access: reset asserted during BUSY_D with mem_ready low -> all outputs 0 immediately. After release, state is IDLE and a new request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage.
// Data wins contention, but a pending fetch is granted after MAX_CONSEC data grants.
module mem_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int MAX_CONSEC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   input  logic              halt,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              if_stall,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int CW = $clog2(MAX_CONSEC + 1);
   localparam logic [CW-1:0] CMAX = CW'(MAX_CONSEC);

   localparam logic [1:0] IDLE           = 2'd0;
   localparam logic [1:0] BUSY_IF        = 2'd1;
   localparam logic [1:0] BUSY_D         = 2'd2;
   localparam logic [1:0] BUSY_IF_CANCEL = 2'd3;

   logic [1:0]        state_r;
   logic [CW-1:0]     consec_r;
   logic              if_done_r;
   logic              d_done_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] d_rdata_r;
   logic              mem_en_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              if_elig_s;
   logic              d_elig_s;
   logic              grant_if_s;
   logic              grant_d_s;

   // Arbitration decision, only meaningful while idle.
   always_comb begin
      if_elig_s  = if_req & ~halt & ~if_flush & ~if_done_r;
      d_elig_s   = d_req & ~d_done_r;
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
      if (state_r == IDLE) begin
         if (if_elig_s && (!d_elig_s || (consec_r == CMAX))) begin
            grant_if_s = 1'b1;
         end else begin
            grant_d_s = d_elig_s;
         end
      end else begin
         grant_if_s = 1'b0;
         grant_d_s  = 1'b0;
      end
   end

   // Access sequencer: latches the granted request and waits for mem_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         if_done_r   <= 1'b0;
         d_done_r    <= 1'b0;
         if_rdata_r  <= {DATA_W{1'b0}};
         d_rdata_r   <= {DATA_W{1'b0}};
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
      end else begin
         if_done_r <= 1'b0;
         d_done_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_if_s) begin
                  state_r     <= BUSY_IF;
                  mem_en_r    <= 1'b1;
                  mem_we_r    <= 1'b0;
                  mem_addr_r  <= if_addr;
                  mem_wdata_r <= d_wdata;
               end else if (grant_d_s) begin
                  state_r     <= BUSY_D;
                  mem_en_r    <= 1'b1;
                  mem_we_r    <= d_we;
                  mem_addr_r  <= d_addr;
                  mem_wdata_r <= d_wdata;
               end
            end
            BUSY_IF: begin
               if (mem_ready) begin
                  state_r  <= IDLE;
                  mem_en_r <= 1'b0;
                  mem_we_r <= 1'b0;
                  // A flush coinciding with completion still cancels the fetch.
                  if (!if_flush) begin
                     if_done_r  <= 1'b1;
                     if_rdata_r <= mem_rdata;
                  end
               end else if (if_flush) begin
                  state_r <= BUSY_IF_CANCEL;
               end
            end
            BUSY_IF_CANCEL: begin
               if (mem_ready) begin
                  state_r  <= IDLE;
                  mem_en_r <= 1'b0;
                  mem_we_r <= 1'b0;
               end
            end
            BUSY_D: begin
               if (mem_ready) begin
                  state_r  <= IDLE;
                  mem_en_r <= 1'b0;
                  mem_we_r <= 1'b0;
                  d_done_r <= 1'b1;
                  if (!mem_we_r) begin
                     d_rdata_r <= mem_rdata;
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
            end
         endcase
      end
   end

   // Counts data grants that overtook a waiting fetch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         consec_r <= {CW{1'b0}};
      end else if (!if_req || grant_if_s) begin
         consec_r <= {CW{1'b0}};
      end else if (grant_d_s && (consec_r != CMAX)) begin
         consec_r <= consec_r + CW'(1);
      end
   end

   assign if_done   = if_done_r;
   assign d_done    = d_done_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_stall  = if_req & ~if_done_r;
   assign d_stall   = d_req & ~d_done_r;

endmodule
